xor_accum: RTL
==============

XOR_ACCUM -- requirements
Module: xor_accum

Interface
- REQ-001: Parameter WIDTH, default 8: data word width in bits, legal range 1..64.
- REQ-002: Parameter FRAME_LEN, default 4: maximum words per frame, legal range 1..256.
- REQ-003: Parameter ODD, default 0: 0 = plain XOR result; 1 = result inverted bitwise (odd-parity mode).
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: in_valid  input  1  in_data/in_last valid this cycle.
- REQ-007: in_ready  output  1  block accepts a word this cycle.
- REQ-008: in_data  input  WIDTH  data word.
- REQ-009: in_last  input  1  marks the final word of a frame.
- REQ-010: out_valid  output  1  frame result valid.
- REQ-011: out_ready  input  1  consumer takes the result this cycle.
- REQ-012: out_data  output  WIDTH  XOR of all words in the frame (inverted when ODD=1).
- REQ-013: out_parity  output  1  XOR-reduction of out_data.
- REQ-014: out_count  output  clog2(FRAME_LEN+1)  number of words in the frame.
- REQ-015: out_trunc  output  1  frame closed by FRAME_LEN limit without in_last.

Function
- REQ-016: A word is accepted only on a rising edge where in_valid=1 and in_ready=1; when in_valid=0, inputs are ignored.
- REQ-017: The state machine SHALL have three states: IDLE (no words accepted), ACC (at least one word accepted), HOLD (result presented).
- REQ-018: in_ready SHALL equal 1 in IDLE and ACC and 0 in HOLD; no bypass exists from HOLD.
- REQ-019: On each accept, acc <= acc ^ in_data and cnt <= cnt + 1; IDLE -> ACC on the first accept.
- REQ-020: A frame closes on the accept where in_last=1 or cnt+1 == FRAME_LEN, whichever comes first.
- REQ-021: On the closing accept, the next state SHALL be HOLD, with these values registered:
  - out_data = acc ^ in_data ^ {WIDTH{ODD}};
  - out_count = cnt+1;
  - out_trunc = (in_last==0).
- REQ-022: out_valid SHALL rise on the edge after the closing accept (1-cycle latency).
- REQ-023: In HOLD, out_valid, out_data, out_parity, out_count and out_trunc SHALL hold stable until out_ready=1.
- REQ-024: HOLD with out_ready=1 SHALL go to IDLE on that edge: out_valid <= 0, acc <= 0, cnt <= 0; in_ready=1 in the following cycle.
- REQ-025: in_last together with cnt+1 == FRAME_LEN SHALL close the frame with out_trunc=0.
- REQ-026: With FRAME_LEN=1, every accepted word closes a frame.
- REQ-027: out_ready asserted outside HOLD SHALL have no effect.
- REQ-028: out_parity SHALL be combinational from the registered out_data.

Reset
- REQ-029: rst_n=0 SHALL immediately force state to IDLE; acc, cnt, out_data, out_count, out_trunc, out_valid to 0; in_ready to 1; out_parity to 0.
- REQ-030: Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result; no output pulse follows reset release.
- REQ-031: The first accept is possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8, FRAME_LEN=4, ODD=0 unless stated)
- REQ-032: Words 0x0F, 0xF0, 0xAA with last on 0xAA -> out_data=0x55, out_parity=0, out_count=3, out_trunc=0, out_valid one cycle after the third accept.
- REQ-033: Words 0x01, 0x02, 0x04, 0x08 with in_last never set -> out_data=0x0F, out_count=4, out_trunc=1; the 5th word is not accepted (in_ready=0).
- REQ-034: out_ready held 0 for 5 cycles in HOLD while in_valid=1 and in_data toggles -> outputs unchanged, in_ready=0; out_ready=1 -> out_valid=0 next cycle, and the next frame starts from acc=0.
- REQ-035: ODD=1, single word 0x00 with last -> out_data=0xFF, out_parity=0, out_count=1.
- REQ-036: Two-word frames (0x00,0x00), (0x00,0x01), (0x01,0x00), (0x01,0x01) -> out_data LSB 0, 1, 1, 0 (two-input XOR truth table).
- REQ-037: rst_n pulsed low after 2 accepts (0x33, 0x44), then frame 0x10 with last -> out_data=0x10, out_count=1, with no output from the aborted frame.

Source files
------------

// File: rtl/xor_accum_if.sv
// Stream bundle for xor_accum: word input channel and frame-result output channel.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface xor_accum_if #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
);
  localparam int CW = $clog2(FRAME_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic [CW-1:0]    out_count;
  logic             out_trunc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_count, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_count, out_trunc
  );
endinterface

// File: rtl/xor_accum.sv
// Frame XOR accumulator: folds words into a running XOR until in_last or the
// FRAME_LEN limit, then holds the registered result until the consumer takes it.
module xor_accum #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  xor_accum_if.slave bus
);
  localparam int               CW       = $clog2(FRAME_LEN + 1);
  localparam logic [WIDTH-1:0] MASK     = (ODD != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CW-1:0]    out_count_reg;
  logic             out_trunc_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;

  logic accept;
  logic close;

  assign accept = bus.in_valid && in_ready_reg;
  // Comparing against FRAME_LEN-1 keeps the test inside the counter width.
  assign close  = bus.in_last || (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_trunc_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      unique case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            if (close) begin
              state_reg     <= HOLD;
              out_data_reg  <= acc_reg ^ bus.in_data ^ MASK;
              out_count_reg <= cnt_reg + 1'b1;
              out_trunc_reg <= !bus.in_last;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
            end else begin
              state_reg <= ACC;
              acc_reg   <= acc_reg ^ bus.in_data;
              cnt_reg   <= cnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_parity = ^out_data_reg;
  assign bus.out_count  = out_count_reg;
  assign bus.out_trunc  = out_trunc_reg;
endmodule
